bitty_sequencer: RTL

- Program sequencer for the Bitty datapath.
- Fetches 16-bit instructions from a program memory over a valid handshake, presents each on Bitty's instruction input, pulses Bitty's run, and waits for done before advancing the PC.
- Stops on a halt opcode, at end of program, or on a watchdog timeout.
- Sits between program memory and the Bitty core, one level above it.

---
 rtl/bitty_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bitty_sequencer.sv
// Program sequencer for the Bitty datapath: fetches instructions from program
// memory, issues each to Bitty with a one-cycle run pulse, and waits for done
// before advancing. Stops on the halt opcode, at the last program slot, or on
// a watchdog timeout.
module bitty_sequencer #(
    parameter int          ADDR_W     = 8,
    parameter int          PROG_LEN   = 256,
    parameter int          TIMEOUT    = 16,
    parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [15:0]       bitty_din,
    output logic              bitty_run,
    input  logic              bitty_done,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count,
    output logic              busy,
    output logic              halted,
    output logic              error
);

    localparam int                TMR_W    = $clog2(TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_LEN - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_HALT,
        S_ERROR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       instr_q, instr_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              mem_rd_q, mem_rd_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              error_q, error_d;

    // Next-state and datapath updates; status outputs are decoded from the
    // next state so they come straight out of flops.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE, S_HALT, S_ERROR: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                if (mem_valid) begin
                    instr_d = mem_rdata;
                    state_d = (mem_rdata == HALT_INSTR) ? S_HALT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                timer_d = timer_q + TMR_W'(1);
                // done takes priority over a coincident timeout
                if (bitty_done) begin
                    cnt_d = cnt_q + 16'd1;
                    if (pc_q == LAST_PC) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        mem_rd_d = (state_d == S_FETCH);
        run_d    = (state_d == S_ISSUE);
        busy_d   = (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_EXEC);
        halted_d = (state_d == S_HALT);
        error_d  = (state_d == S_ERROR);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            instr_q  <= '0;
            timer_q  <= '0;
            mem_rd_q <= 1'b0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            timer_q  <= timer_d;
            mem_rd_q <= mem_rd_d;
            run_q    <= run_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            error_q  <= error_d;
        end
    end

    assign mem_addr    = pc_q;
    assign mem_rd      = mem_rd_q;
    assign bitty_din   = instr_q;
    assign bitty_run   = run_q;
    assign pc          = pc_q;
    assign instr_count = cnt_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign error       = error_q;

endmodule
